// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode constants and parameter legality check for counter_mod_n
package counter_pkg;

   localparam int MODE_DIRECT = 0;
   localparam int MODE_BOUNCE = 1;

   function automatic bit params_legal(input int     width,
                                       input longint modulus,
                                       input int     mode,
                                       input int     saturate,
                                       input longint reset_value);
      bit ok;
      ok = (width >= 2) && (width <= 32);
      ok = ok && (modulus >= 2) && (modulus <= (longint'(1) << width));
      ok = ok && ((mode == MODE_DIRECT) || (mode == MODE_BOUNCE));
      ok = ok && ((saturate == 0) || (saturate == 1));
      ok = ok && (reset_value >= 0) && (reset_value < modulus);
      return ok;
   endfunction

endpackage

// File: rtl/counter_step.sv
// rtl/counter_step.sv - next-count, next-direction and end detection for counter_mod_n
module counter_step
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 8,
   parameter longint MODULUS  = 200,
   parameter int     MODE     = MODE_DIRECT,
   parameter int     SATURATE = 0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir_up,
   output logic [WIDTH-1:0] next_count,
   output logic             next_dir_up,
   output logic             at_end
);

   localparam int             EW  = WIDTH + 1;
   localparam logic [WIDTH:0] TOP = EW'(MODULUS - 1);

   // One spare bit keeps MODULUS = 2^WIDTH arithmetic free of overflow.
   logic [WIDTH:0] cur;
   logic [WIDTH:0] inc;
   logic [WIDTH:0] dec;
   logic [WIDTH:0] nxt;
   logic           unused_msb;

   always_comb begin
      cur         = {1'b0, count};
      inc         = cur + EW'(1);
      dec         = cur - EW'(1);
      at_end      = dir_up ? (cur == TOP) : (cur == '0);
      nxt         = dir_up ? inc : dec;
      next_dir_up = dir_up;
      if (at_end) begin
         if (MODE == MODE_BOUNCE) begin
            nxt         = dir_up ? dec : inc;
            next_dir_up = ~dir_up;
         end else if (SATURATE != 0) begin
            nxt = cur;
         end else begin
            nxt = dir_up ? '0 : TOP;
         end
      end
   end

   assign next_count = nxt[WIDTH-1:0];
   assign unused_msb = nxt[WIDTH];

endmodule

// File: rtl/counter_mod_n.sv
// rtl/counter_mod_n.sv - modulo-N counter with direct/bounce modes, wrap/saturate and cascade carry
module counter_mod_n
   import counter_pkg::*;
#(
   parameter int     WIDTH       = 8,
   parameter longint MODULUS     = 200,
   parameter int     MODE        = MODE_DIRECT,
   parameter int     SATURATE    = 0,
   parameter longint RESET_VALUE = 0
) (
   input  logic             i_CLOCK_POS,
   input  logic             i_RESET_POS,
   input  logic             i_BIT_ENABLE,
   input  logic             i_BIT_UP,
   input  logic             i_BIT_CLEAR,
   input  logic             i_BIT_LOAD,
   input  logic [WIDTH-1:0] i_VECTOR_LOAD,
   output logic [WIDTH-1:0] o_VECTOR_OUT,
   output logic             o_BIT_TERMINAL,
   output logic             o_BIT_EVENT,
   output logic             o_BIT_DIR_UP
);

   localparam int               EW      = WIDTH + 1;
   localparam logic [WIDTH:0]   TOP     = EW'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);

   if (!params_legal(WIDTH, MODULUS, MODE, SATURATE, RESET_VALUE)) begin : g_illegal_params
      $error("counter_mod_n: illegal parameter set");
   end

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] step_count;
   logic [WIDTH-1:0] load_value;
   logic             dir_q;
   logic             dir_eff;
   logic             step_dir;
   logic             at_end;
   logic             terminal;
   logic             event_q;

   assign dir_eff = (MODE == MODE_BOUNCE) ? dir_q : i_BIT_UP;

   counter_step #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .MODE     (MODE),
      .SATURATE (SATURATE)
   ) u_step (
      .count       (count_q),
      .dir_up      (dir_eff),
      .next_count  (step_count),
      .next_dir_up (step_dir),
      .at_end      (at_end)
   );

   assign load_value = ({1'b0, i_VECTOR_LOAD} > TOP) ? TOP[WIDTH-1:0] : i_VECTOR_LOAD;
   assign terminal   = i_BIT_ENABLE & at_end & ~i_BIT_CLEAR & ~i_BIT_LOAD;

   always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
      if (i_RESET_POS) begin
         count_q <= RST_CNT;
         dir_q   <= 1'b1;
         event_q <= 1'b0;
      end else begin
         event_q <= terminal;
         if (i_BIT_CLEAR) begin
            count_q <= '0;
            dir_q   <= 1'b1;
         end else if (i_BIT_LOAD) begin
            count_q <= load_value;
         end else if (i_BIT_ENABLE) begin
            count_q <= step_count;
            dir_q   <= step_dir;
         end
      end
   end

   assign o_VECTOR_OUT   = count_q;
   assign o_BIT_TERMINAL = terminal;
   assign o_BIT_EVENT    = event_q;
   assign o_BIT_DIR_UP   = dir_eff;

endmodule
